// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } ifu_state_e;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO with a registered head entry.
// Flush empties the queue but leaves the head register untouched.
import ifu_pkg::*;

module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   din,
  output logic [AW:0]   count,
  output logic [63:0]   head
);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt_q;
  logic [63:0]   head_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush &&
                   (cnt_q != (AW+1)'(DEPTH));
  assign do_pop  = pop && !flush &&
                   (cnt_q != '0);
  assign rd_nxt  = rd_q + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_nxt;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Head tracks the entry that will be oldest after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
    end else if (do_push &&
                 ((cnt_q == '0) ||
                  ((cnt_q == (AW+1)'(1)) && do_pop))) begin
      head_q <= din;
    end else if (do_pop &&
                 (cnt_q > (AW+1)'(1))) begin
      head_q <= mem_q[rd_nxt];
    end
  end

  assign count = cnt_q;
  assign head  = head_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, fetch FSM, branch redirect and prefetch FIFO.
// Define IFU_MISALIGN_TRAP_EN to trap on misaligned branch targets.
import ifu_pkg::*;

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] inst_address,
  output logic        inst_read,
  input  logic [31:0] inst_out,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        if_fault,
`endif
  input  logic        branch_valid,
  input  logic [31:0] branch_target
);

  localparam int AW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;

  ifu_state_e   state_q;
  ifu_state_e   state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [AW:0]  count;
  logic [63:0]  head_raw;
  fetch_entry_t head;
  fetch_entry_t push_ent;
  logic         flush;
  logic         br_load;
  logic [31:0]  br_pc;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = branch_target[1:0] != 2'b00;
  assign flush    = branch_valid && (state_q != FAULT);
  assign br_load  = flush && !misalign;
  assign br_pc    = branch_target;
`else
  assign flush    = branch_valid;
  assign br_load  = branch_valid;
  assign br_pc    = branch_target & ~32'h3;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
`ifdef IFU_MISALIGN_TRAP_EN
      FAULT:   state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
`ifdef IFU_MISALIGN_TRAP_EN
    if (flush && misalign) state_d = FAULT;
`endif
  end

  always_comb begin
    inst_read = (state_q == RUN) && fetch_en &&
                (count < (AW+1)'(FIFO_DEPTH));
`ifdef IFU_MISALIGN_TRAP_EN
    if_fault  = state_q == FAULT;
`endif
  end

  always_comb begin
    pc_d = pc_q;
    if (br_load)
      pc_d = br_pc;
    else if (inst_read && !flush)
      pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign push_ent.pc   = pc_q;
  assign push_ent.inst = inst_out;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inst_read),
    .pop   (if_valid && id_ready),
    .flush (flush),
    .din   (push_ent),
    .count (count),
    .head  (head_raw)
  );

  assign head         = fetch_entry_t'(head_raw);
  assign inst_address = pc_q;
  assign if_valid     = count != '0;
  assign if_inst      = head.inst;
  assign if_pc        = head.pc;

endmodule
